// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding and
// default geometry of the PC and instruction words.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    FULL    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_e;

  localparam int DEF_PC_WIDTH    = 8;
  localparam int DEF_INSTR_WIDTH = 8;
  localparam int DEF_RESET_PC    = 0;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundles the instruction-memory handshake and the decode-side buffer of the
// fetch stage; master is the fetch unit, slave is memory plus decode.
interface instr_fetch_unit_if
  import fetch_pkg::*;
#(
  parameter int PC_WIDTH    = DEF_PC_WIDTH,
  parameter int INSTR_WIDTH = DEF_INSTR_WIDTH
);

  logic                   imem_req;
  logic [PC_WIDTH-1:0]    imem_addr;
  logic                   imem_ack;
  logic [INSTR_WIDTH-1:0] imem_rdata;

  logic [INSTR_WIDTH-1:0] instr_out;
  logic                   instr_valid;
  logic                   instr_ready;
  logic [PC_WIDTH-1:0]    pc_out;
  logic [PC_WIDTH-1:0]    link_pc;

  logic                   redirect;
  logic [PC_WIDTH-1:0]    redirect_target;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output instr_out, instr_valid, pc_out, link_pc,
    input  instr_ready, redirect, redirect_target
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  instr_out, instr_valid, pc_out, link_pc,
    output instr_ready, redirect, redirect_target
  );

endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, issues one req/ack read at a time and presents
// each instruction to decode through a single-entry valid/ready buffer.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int PC_WIDTH    = DEF_PC_WIDTH,
  parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
  parameter int RESET_PC    = DEF_RESET_PC
)(
  input  logic                clk,
  input  logic                reset,
  instr_fetch_unit_if.master  bus
);

  localparam logic [PC_WIDTH-1:0] RST_PC  = PC_WIDTH'(RESET_PC);
  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(1);

  fetch_state_e           state_q,    state_d;
  logic [PC_WIDTH-1:0]    fetch_pc_q, fetch_pc_d;
  logic [PC_WIDTH-1:0]    req_addr_q, req_addr_d;
  logic [PC_WIDTH-1:0]    pc_out_q,   pc_out_d;
  logic [INSTR_WIDTH-1:0] instr_q,    instr_d;

  // Next-state logic. req_addr is reloaded on every entry to REQ, so the
  // address seen by memory never changes while a request is outstanding.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    pc_out_d   = pc_out_q;
    instr_d    = instr_q;

    unique case (state_q)
      IDLE: begin
        state_d = REQ;
        if (bus.redirect) begin
          fetch_pc_d = bus.redirect_target;
          req_addr_d = bus.redirect_target;
        end else begin
          req_addr_d = fetch_pc_q;
        end
      end

      REQ: begin
        if (bus.imem_ack && bus.redirect) begin
          fetch_pc_d = bus.redirect_target;
          req_addr_d = bus.redirect_target;
          state_d    = REQ;
        end else if (bus.imem_ack) begin
          instr_d    = bus.imem_rdata;
          pc_out_d   = req_addr_q;
          fetch_pc_d = req_addr_q + PC_STEP;
          state_d    = FULL;
        end else if (bus.redirect) begin
          fetch_pc_d = bus.redirect_target;
          state_d    = DISCARD;
        end
      end

      FULL: begin
        if (bus.redirect) begin
          fetch_pc_d = bus.redirect_target;
          req_addr_d = bus.redirect_target;
          state_d    = REQ;
        end else if (bus.instr_ready) begin
          req_addr_d = fetch_pc_q;
          state_d    = REQ;
        end
      end

      DISCARD: begin
        // The protocol has no abort, so the stale read must complete first.
        if (bus.imem_ack) begin
          state_d = REQ;
          if (bus.redirect) begin
            fetch_pc_d = bus.redirect_target;
            req_addr_d = bus.redirect_target;
          end else begin
            req_addr_d = fetch_pc_q;
          end
        end else if (bus.redirect) begin
          fetch_pc_d = bus.redirect_target;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RST_PC;
      req_addr_q <= '0;
      pc_out_q   <= '0;
      instr_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      pc_out_q   <= pc_out_d;
      instr_q    <= instr_d;
    end
  end

  assign bus.imem_req    = (state_q == REQ) || (state_q == DISCARD);
  assign bus.imem_addr   = req_addr_q;
  assign bus.instr_valid = (state_q == FULL);
  assign bus.instr_out   = instr_q;
  assign bus.pc_out      = pc_out_q;
  assign bus.link_pc     = pc_out_q + PC_STEP;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed, table-driven bench for instr_fetch_unit: one record per clock
// cycle, plus a hand-written asynchronous reset sequence.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  typedef struct {
    logic       ack;
    logic [7:0] rdata;
    logic       ready;
    logic       redir;
    logic [7:0] target;
    logic       eReq;
    logic [7:0] eAddr;
    logic       eValid;
    logic [7:0] eInstr;
    logic [7:0] ePc;
  } vec_t;

  logic clk;
  logic reset;
  int   compared;
  int   mismatched;
  vec_t vecs[$];

  instr_fetch_unit_if #(.PC_WIDTH(8), .INSTR_WIDTH(8)) bus ();

  instr_fetch_unit #(.PC_WIDTH(8), .INSTR_WIDTH(8), .RESET_PC(0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] memWord(input logic [7:0] a);
    return a ^ 8'h5A;
  endfunction

  task automatic addVec(input logic ack, input logic [7:0] rdata, input logic ready,
                        input logic redir, input logic [7:0] target,
                        input logic eReq, input logic [7:0] eAddr, input logic eValid,
                        input logic [7:0] eInstr, input logic [7:0] ePc);
    vec_t v;
    v.ack = ack; v.rdata = rdata; v.ready = ready; v.redir = redir; v.target = target;
    v.eReq = eReq; v.eAddr = eAddr; v.eValid = eValid; v.eInstr = eInstr; v.ePc = ePc;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string nm, input int idx,
                             input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s (step %0d): got %h, want %h", nm, idx, act, exp);
    end
  endtask

  task automatic checkAll(input int idx, input logic eReq, input logic [7:0] eAddr,
                          input logic eValid, input logic [7:0] eInstr,
                          input logic [7:0] ePc);
    logic [7:0] eLink;
    eLink = ePc + 8'd1;
    checkOutput("imem_req",    idx, {7'd0, bus.imem_req},    {7'd0, eReq});
    checkOutput("imem_addr",   idx, bus.imem_addr,           eAddr);
    checkOutput("instr_valid", idx, {7'd0, bus.instr_valid}, {7'd0, eValid});
    checkOutput("instr_out",   idx, bus.instr_out,           eInstr);
    checkOutput("pc_out",      idx, bus.pc_out,              ePc);
    checkOutput("link_pc",     idx, bus.link_pc,             eLink);
  endtask

  // Called just after a falling edge: drive, let one rising edge pass, check.
  task automatic applyStimulus(input int idx, input vec_t v);
    bus.imem_ack        = v.ack;
    bus.imem_rdata      = v.rdata;
    bus.instr_ready     = v.ready;
    bus.redirect        = v.redir;
    bus.redirect_target = v.target;
    @(posedge clk);
    #1;
    checkAll(idx, v.eReq, v.eAddr, v.eValid, v.eInstr, v.ePc);
    @(negedge clk);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;

    // Reset state and first fetch with ack tied high.
    addVec(1, memWord(8'h00), 0, 0, 8'h00,   1, 8'h00, 0, 8'h00,           8'h00);
    addVec(1, memWord(8'h00), 0, 0, 8'h00,   0, 8'h00, 1, memWord(8'h00),  8'h00);
    // Sequential run, ack latency 2, ready held high.
    addVec(0, 8'h00,          1, 0, 8'h00,   1, 8'h01, 0, memWord(8'h00),  8'h00);
    addVec(0, 8'h00,          1, 0, 8'h00,   1, 8'h01, 0, memWord(8'h00),  8'h00);
    addVec(0, 8'h00,          1, 0, 8'h00,   1, 8'h01, 0, memWord(8'h00),  8'h00);
    addVec(1, memWord(8'h01), 1, 0, 8'h00,   0, 8'h01, 1, memWord(8'h01),  8'h01);
    addVec(0, 8'h00,          1, 0, 8'h00,   1, 8'h02, 0, memWord(8'h01),  8'h01);
    addVec(0, 8'h00,          1, 0, 8'h00,   1, 8'h02, 0, memWord(8'h01),  8'h01);
    addVec(0, 8'h00,          1, 0, 8'h00,   1, 8'h02, 0, memWord(8'h01),  8'h01);
    addVec(1, memWord(8'h02), 1, 0, 8'h00,   0, 8'h02, 1, memWord(8'h02),  8'h02);
    addVec(0, 8'h00,          1, 0, 8'h00,   1, 8'h03, 0, memWord(8'h02),  8'h02);
    addVec(0, 8'h00,          1, 0, 8'h00,   1, 8'h03, 0, memWord(8'h02),  8'h02);
    addVec(0, 8'h00,          1, 0, 8'h00,   1, 8'h03, 0, memWord(8'h02),  8'h02);
    addVec(1, memWord(8'h03), 1, 0, 8'h00,   0, 8'h03, 1, memWord(8'h03),  8'h03);
    // Back-pressure for five cycles; a stray ack with req low is ignored.
    addVec(0, 8'h00,          0, 0, 8'h00,   0, 8'h03, 1, memWord(8'h03),  8'h03);
    addVec(0, 8'h00,          0, 0, 8'h00,   0, 8'h03, 1, memWord(8'h03),  8'h03);
    addVec(1, 8'hEE,          0, 0, 8'h00,   0, 8'h03, 1, memWord(8'h03),  8'h03);
    addVec(0, 8'h00,          0, 0, 8'h00,   0, 8'h03, 1, memWord(8'h03),  8'h03);
    addVec(0, 8'h00,          0, 0, 8'h00,   0, 8'h03, 1, memWord(8'h03),  8'h03);
    addVec(0, 8'h00,          1, 0, 8'h00,   1, 8'h04, 0, memWord(8'h03),  8'h03);
    addVec(1, memWord(8'h04), 0, 0, 8'h00,   0, 8'h04, 1, memWord(8'h04),  8'h04);
    // Redirect to 0x40 while FULL and not consumed.
    addVec(0, 8'h00,          0, 1, 8'h40,   1, 8'h40, 0, memWord(8'h04),  8'h04);
    addVec(1, memWord(8'h40), 0, 0, 8'h00,   0, 8'h40, 1, memWord(8'h40),  8'h40);
    // Consume plus redirect to 0x05, then redirect to 0x80 mid-request (latency 3).
    addVec(0, 8'h00,          1, 1, 8'h05,   1, 8'h05, 0, memWord(8'h40),  8'h40);
    addVec(0, 8'h00,          0, 1, 8'h80,   1, 8'h05, 0, memWord(8'h40),  8'h40);
    addVec(0, 8'h00,          0, 0, 8'h00,   1, 8'h05, 0, memWord(8'h40),  8'h40);
    addVec(0, 8'h00,          0, 0, 8'h00,   1, 8'h05, 0, memWord(8'h40),  8'h40);
    addVec(1, memWord(8'h05), 0, 0, 8'h00,   1, 8'h80, 0, memWord(8'h40),  8'h40);
    // Ack and redirect together, then repeated redirects while discarding.
    addVec(1, memWord(8'h80), 0, 1, 8'h90,   1, 8'h90, 0, memWord(8'h40),  8'h40);
    addVec(0, 8'h00,          0, 1, 8'hA0,   1, 8'h90, 0, memWord(8'h40),  8'h40);
    addVec(0, 8'h00,          0, 1, 8'hB0,   1, 8'h90, 0, memWord(8'h40),  8'h40);
    addVec(1, memWord(8'h90), 0, 0, 8'h00,   1, 8'hB0, 0, memWord(8'h40),  8'h40);
    addVec(1, memWord(8'hB0), 0, 0, 8'h00,   0, 8'hB0, 1, memWord(8'hB0),  8'hB0);
    // Wrap from 0xFF to 0x00.
    addVec(0, 8'h00,          0, 1, 8'hFF,   1, 8'hFF, 0, memWord(8'hB0),  8'hB0);
    addVec(1, memWord(8'hFF), 0, 0, 8'h00,   0, 8'hFF, 1, memWord(8'hFF),  8'hFF);
    addVec(0, 8'h00,          1, 0, 8'h00,   1, 8'h00, 0, memWord(8'hFF),  8'hFF);
    addVec(1, memWord(8'h00), 0, 0, 8'h00,   0, 8'h00, 1, memWord(8'h00),  8'h00);
    addVec(0, 8'h00,          1, 0, 8'h00,   1, 8'h01, 0, memWord(8'h00),  8'h00);

    reset               = 1'b0;
    bus.imem_ack        = 1'b1;
    bus.imem_rdata      = memWord(8'h00);
    bus.instr_ready     = 1'b0;
    bus.redirect        = 1'b0;
    bus.redirect_target = 8'h00;
    repeat (3) @(negedge clk);
    checkAll(-1, 0, 8'h00, 0, 8'h00, 8'h00);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) applyStimulus(i, vecs[i]);

    // Asynchronous reset while a request to 0x01 is outstanding.
    #2;
    bus.imem_ack = 1'b0;
    reset        = 1'b0;
    #1;
    checkAll(100, 0, 8'h00, 0, 8'h00, 8'h00);
    @(negedge clk);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 8'h33;
    reset          = 1'b1;
    @(posedge clk);
    #1;
    checkAll(101, 1, 8'h00, 0, 8'h00, 8'h00);
    @(negedge clk);
    bus.imem_rdata = memWord(8'h00);
    @(posedge clk);
    #1;
    checkAll(102, 0, 8'h00, 1, memWord(8'h00), 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
